tb_mem_ctrl: RTL



---
 rtl/tb_mem_ctrl_if.sv | 25 ++
 rtl/tb_mem_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tb_mem_ctrl_if.sv
// Memory-port bundle between the harness AXI-to-memory bridge and tb_mem_ctrl.
// The bridge drives the master side, the controller the slave side.
interface tb_mem_ctrl_if #(
    parameter int AddrWidth = 12,
    parameter int DataWidth = 64
);
    logic                     req;
    logic                     gnt;
    logic [AddrWidth-1:0]     addr;
    logic                     we;
    logic [DataWidth-1:0]     wdata;
    logic [DataWidth/8-1:0]   strb;
    logic                     rvalid;
    logic [DataWidth-1:0]     rdata;

    modport master (
        output req, addr, we, wdata, strb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata, strb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/tb_mem_ctrl.sv
// Memory-port controller in front of a single-port SRAM model: strobes,
// fixed response latency, optional LFSR grant stalls and access counters.
module tb_mem_ctrl #(
    parameter int          NumWords  = 256,
    parameter int          DataWidth = 64,
    parameter int          AddrWidth = 12,
    parameter int          Latency   = 1,
    parameter int          StallEn   = 0,
    parameter int          MaxStall  = 3,
    parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    tb_mem_ctrl_if.slave                 mem,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(NumWords)-1:0]  sram_addr_o,
    output logic [DataWidth-1:0]         sram_wdata_o,
    output logic [DataWidth/8-1:0]       sram_be_o,
    input  logic [DataWidth-1:0]         sram_rdata_i,
    output logic [31:0]                  rd_cnt_o,
    output logic [31:0]                  wr_cnt_o,
    output logic [31:0]                  err_cnt_o
);
    localparam int StrbW = DataWidth / 8;
    localparam int OffW  = $clog2(StrbW);
    localparam int IdxW  = AddrWidth - OffW;
    localparam int WordW = $clog2(NumWords);
    localparam logic [15:0] Seed = (LfsrSeed == 16'h0) ? 16'hACE1 : LfsrSeed;
    localparam logic [DataWidth-1:0] ErrPat = {(DataWidth / 32){32'hDEADBEEF}};

    typedef enum logic [1:0] {KindRd, KindWr, KindErr} kind_e;

    logic [15:0]          lfsr_q, lfsr_d;
    logic [3:0]           stall_q, stall_d;
    logic [31:0]          rd_cnt_q, rd_cnt_d;
    logic [31:0]          wr_cnt_q, wr_cnt_d;
    logic [31:0]          err_cnt_q, err_cnt_d;
    logic [Latency-1:0]   vld_q, vld_d;
    kind_e                kind_q [Latency];
    kind_e                kind_d [Latency];
    logic [IdxW-1:0]      word_idx;
    logic                 in_range;
    logic                 gnt;
    kind_e                kind_in;
    logic [DataWidth-1:0] rsp_data;
    logic                 unused_addr;

    assign word_idx    = mem.addr[AddrWidth-1:OffW];
    assign in_range    = ~|(word_idx >> WordW);
    assign unused_addr = ^mem.addr[OffW-1:0];

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        gnt    = mem.req;
        // A stalled request is forced through once the bound is reached.
        if (StallEn != 0) begin
            gnt = mem.req & (~lfsr_q[0] | (stall_q == 4'(MaxStall)));
        end
        stall_d   = (mem.req && !gnt) ? stall_q + 4'd1 : 4'd0;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        kind_in   = KindRd;
        if (!in_range) begin
            kind_in = KindErr;
        end else if (mem.we) begin
            kind_in = KindWr;
        end
        if (gnt) begin
            unique case (kind_in)
                KindRd:  rd_cnt_d  = rd_cnt_q + 32'd1;
                KindWr:  wr_cnt_d  = wr_cnt_q + 32'd1;
                default: err_cnt_d = err_cnt_q + 32'd1;
            endcase
        end
    end

    always_comb begin
        sram_req_o   = gnt & in_range;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (sram_req_o) begin
            sram_we_o    = mem.we;
            sram_addr_o  = word_idx[WordW-1:0];
            sram_wdata_o = mem.wdata;
            sram_be_o    = mem.strb;
        end
    end

    always_comb begin
        vld_d[0]  = gnt;
        kind_d[0] = kind_in;
        for (int i = 1; i < Latency; i++) begin
            vld_d[i]  = vld_q[i-1];
            kind_d[i] = kind_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q    <= Seed;
            stall_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            vld_q     <= '0;
            for (int i = 0; i < Latency; i++) kind_q[i] <= KindRd;
        end else begin
            lfsr_q    <= lfsr_d;
            stall_q   <= stall_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            vld_q     <= vld_d;
            for (int i = 0; i < Latency; i++) kind_q[i] <= kind_d[i];
        end
    end

    // SRAM data arrives one cycle after grant; pad the remaining latency.
    if (Latency == 1) begin : g_nodly
        assign rsp_data = sram_rdata_i;
    end else begin : g_dly
        logic [DataWidth-1:0] dat_q [Latency-1];
        logic [DataWidth-1:0] dat_d [Latency-1];

        always_comb begin
            dat_d[0] = sram_rdata_i;
            for (int i = 1; i < Latency - 1; i++) dat_d[i] = dat_q[i-1];
        end

        always_ff @(posedge clk_i) begin
            for (int i = 0; i < Latency - 1; i++) dat_q[i] <= dat_d[i];
        end

        assign rsp_data = dat_q[Latency-2];
    end

    always_comb begin
        mem.gnt    = gnt;
        mem.rvalid = vld_q[Latency-1];
        mem.rdata  = '0;
        if (vld_q[Latency-1]) begin
            unique case (kind_q[Latency-1])
                KindRd:  mem.rdata = rsp_data;
                KindErr: mem.rdata = ErrPat;
                default: mem.rdata = '0;
            endcase
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign err_cnt_o = err_cnt_q;
endmodule
